// File: rtl/ahb_slave_mem.sv
// AHB-Lite register-memory responder: programmable wait states, two-cycle ERROR responses.
// Optional sub-word (byte/halfword) access is enabled by defining AHB_SLAVE_SUBWORD_EN.
module ahb_slave_mem #(
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int WORDS = 1 << IW;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t        state;
  logic [1:0]    wait_cnt;
  logic          dp_vld;
  logic          dp_write;
  logic [IW-1:0] dp_idx;
  logic [2:0]    dp_size;
  logic [1:0]    dp_lane;
  logic [31:0]   mem [WORDS];

  logic       accept;
  logic       legal;
  logic       commit;
  logic [3:0] byte_en;

  // Only accept while this slave is itself ready (IDLE/ERR2); hready alone is the bus view.
  assign accept = hsel & hready & htrans[1] & hreadyout;

`ifdef AHB_SLAVE_SUBWORD_EN
  always_comb begin
    legal = 1'b0;
    case (hsize)
      3'b000:  legal = 1'b1;
      3'b001:  legal = (haddr[0] == 1'b0);
      3'b010:  legal = (haddr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    byte_en = 4'h0;
    case (dp_size)
      3'b000:  byte_en = 4'b0001 << dp_lane;
      3'b001:  byte_en = 4'b0011 << dp_lane;
      default: byte_en = 4'b1111;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{haddr[31:ADDR_WIDTH], htrans[0]};
`else
  assign legal   = (hsize == 3'b010) && (haddr[1:0] == 2'b00);
  assign byte_en = 4'b1111;

  logic unused_bits;
  assign unused_bits = ^{haddr[31:ADDR_WIDTH], htrans[0], dp_size, dp_lane};
`endif

  // A legal data phase completes on the IDLE cycle that follows the accept or the wait run.
  assign commit = dp_vld & dp_write & (state == ST_IDLE);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= ST_IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      wait_cnt  <= 2'd0;
      dp_vld    <= 1'b0;
      dp_write  <= 1'b0;
      dp_idx    <= '0;
      dp_size   <= 3'b000;
      dp_lane   <= 2'b00;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          if (accept) begin
            dp_vld   <= legal;
            dp_write <= hwrite;
            dp_idx   <= haddr[ADDR_WIDTH-1:2];
            dp_size  <= hsize;
            dp_lane  <= haddr[1:0];
            if (!legal) begin
              state     <= ST_ERR1;
              hreadyout <= 1'b0;
              hresp     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state     <= ST_WAIT;
              wait_cnt  <= 2'(WAIT_STATES);
              hreadyout <= 1'b0;
              hresp     <= 1'b0;
            end else begin
              state     <= ST_IDLE;
              hreadyout <= 1'b1;
              hresp     <= 1'b0;
            end
          end else begin
            dp_vld    <= 1'b0;
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt <= 2'd1) begin
            state     <= ST_IDLE;
            wait_cnt  <= 2'd0;
            hreadyout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
    end else if (commit) begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) mem[dp_idx][8*b +: 8] <= hwdata[8*b +: 8];
    end
  end

  assign hrdata = (dp_vld && !dp_write) ? mem[dp_idx] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: three instances with WAIT_STATES 1, 0 and 3 share one bus.
module tb_ahb_slave_mem;

  logic        hclk;
  logic        hresetn;
  logic        hsel_bus;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hold;
  int          tgt;

  logic [2:0]  rdy_i;
  logic [2:0]  resp_i;
  logic [31:0] rd0, rd1, rd2;
  logic        rdy, resp;
  logic [31:0] rd;

  int n_chk  = 0;
  int n_fail = 0;

  ahb_slave_mem #(.ADDR_WIDTH(6), .WAIT_STATES(1)) u_ws1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_bus && tgt == 0), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hready(rdy_i[0] & ~hold), .hreadyout(rdy_i[0]), .hresp(resp_i[0]), .hrdata(rd0));

  ahb_slave_mem #(.ADDR_WIDTH(6), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_bus && tgt == 1), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hready(rdy_i[1] & ~hold), .hreadyout(rdy_i[1]), .hresp(resp_i[1]), .hrdata(rd1));

  ahb_slave_mem #(.ADDR_WIDTH(6), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_bus && tgt == 2), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hready(rdy_i[2] & ~hold), .hreadyout(rdy_i[2]), .hresp(resp_i[2]), .hrdata(rd2));

  always_comb begin
    rdy  = rdy_i[0];
    resp = resp_i[0];
    rd   = rd0;
    if (tgt == 1) begin
      rdy = rdy_i[1]; resp = resp_i[1]; rd = rd1;
    end else if (tgt == 2) begin
      rdy = rdy_i[2]; resp = resp_i[2]; rd = rd2;
    end
  end

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr(input logic w, input logic [31:0] a, input logic [2:0] s);
    hsel_bus = 1'b1; htrans = 2'b10; hwrite = w; haddr = a; hsize = s;
  endtask

  task automatic idle();
    hsel_bus = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  // Returns at the falling edge of the final data-phase cycle, before the ending edge.
  task automatic dphase(input logic [31:0] wd, output int waits, output logic r1,
                        output logic rf, output logic [31:0] rdat);
    logic done;
    done = 1'b0; hwdata = wd; waits = 0; r1 = 1'b0; rf = 1'b0; rdat = 32'h0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge hclk);
      if (i == 0) r1 = resp;
      if (rdy) begin
        done = 1'b1; rf = resp; rdat = rd;
      end else begin
        waits++;
        tick();
      end
    end
    check("dphase_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic xfer(input string tag, input logic w, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] wd, input int exp_waits, input logic exp_err,
                      input logic [31:0] exp_rd);
    int waits; logic r1, rf; logic [31:0] d;
    addr(w, a, s);
    tick();
    idle();
    dphase(wd, waits, r1, rf, d);
    check({tag, "_waits"}, waits, exp_waits);
    check({tag, "_resp1"}, {31'b0, r1}, {31'b0, exp_err});
    check({tag, "_respf"}, {31'b0, rf}, {31'b0, exp_err});
    check({tag, "_rdata"}, d, exp_rd);
    tick();
  endtask

  // Write followed by a pipelined read of the same word.
  task automatic wr_rd(input string tag, input logic [31:0] a, input logic [31:0] wd, input int ws);
    int waits; logic r1, rf; logic [31:0] d;
    addr(1'b1, a, 3'b010);
    tick();
    idle();
    dphase(wd, waits, r1, rf, d);
    check({tag, "_wr_waits"}, waits, ws);
    addr(1'b0, a, 3'b010);
    tick();
    idle();
    dphase(32'h0, waits, r1, rf, d);
    check({tag, "_rd_waits"}, waits, ws);
    check({tag, "_rd_resp"}, {31'b0, rf}, 32'd0);
    check({tag, "_rd_data"}, d, wd);
    tick();
  endtask

  task automatic ign(input string tag, input logic sel, input logic [1:0] trans);
    hsel_bus = sel; htrans = trans; hwrite = 1'b1; haddr = 32'h0; hsize = 3'b010;
    tick();
    hwdata = 32'hFFFF_FFFF;
    idle();
    @(negedge hclk);
    check({tag, "_rdy"}, {31'b0, rdy}, 32'd1);
    check({tag, "_resp"}, {31'b0, resp}, 32'd0);
    tick();
  endtask

  initial begin
    hresetn = 1'b0; hold = 1'b0; tgt = 0; hwdata = 32'h0; haddr = 32'h0; hsize = 3'b010;
    idle();
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("reset_rdy", {31'b0, rdy}, 32'd1);
    check("reset_resp", {31'b0, resp}, 32'd0);
    check("reset_rdata", rd, 32'h0);
    tick();
    hresetn = 1'b1;
    tick();

    xfer("rst_rd04", 1'b0, 32'h04, 3'b010, 32'h0, 1, 1'b0, 32'h0);

    tgt = 0; wr_rd("rt_ws1", 32'h08, 32'hDEAD_BEEF, 1);
    tgt = 1; wr_rd("rt_ws0", 32'h08, 32'hDEAD_BEEF, 0);
    tgt = 2; wr_rd("rt_ws3", 32'h08, 32'hDEAD_BEEF, 3);

    tgt = 0;
    xfer("w00",    1'b1, 32'h00, 3'b010, 32'h5555_AAAA, 1, 1'b0, 32'h0);
    xfer("unal",   1'b1, 32'h02, 3'b010, 32'h0000_1111, 1, 1'b1, 32'h0);
    xfer("rd00",   1'b0, 32'h00, 3'b010, 32'h0,         1, 1'b0, 32'h5555_AAAA);

    tgt = 2;
    xfer("sz3_ws3", 1'b1, 32'h04, 3'b011, 32'h1234_5678, 1, 1'b1, 32'h0);
    xfer("rd04_ws3", 1'b0, 32'h04, 3'b010, 32'h0,       3, 1'b0, 32'h0);

    tgt = 0;
    xfer("w0c",    1'b1, 32'h0C, 3'b010, 32'h1122_3344, 1, 1'b0, 32'h0);
`ifdef AHB_SLAVE_SUBWORD_EN
    xfer("byte0d", 1'b1, 32'h0D, 3'b000, 32'h0000_AB00, 1, 1'b0, 32'h0);
    xfer("rd0c",   1'b0, 32'h0C, 3'b010, 32'h0,         1, 1'b0, 32'h1122_AB44);
`else
    xfer("byte0d", 1'b1, 32'h0D, 3'b000, 32'h0000_AB00, 1, 1'b1, 32'h0);
    xfer("rd0c",   1'b0, 32'h0C, 3'b010, 32'h0,         1, 1'b0, 32'h1122_3344);
`endif
    xfer("half0d", 1'b1, 32'h0D, 3'b001, 32'h0000_CDEF, 1, 1'b1, 32'h0);

    ign("ign_idle", 1'b1, 2'b00);
    ign("ign_busy", 1'b1, 2'b01);
    ign("ign_nsel", 1'b0, 2'b10);
    hold = 1'b1;
    addr(1'b1, 32'h00, 3'b010);
    tick();
    idle();
    hold = 1'b0;
    hwdata = 32'h0BAD_0BAD;
    @(negedge hclk);
    check("hold_rdy", {31'b0, rdy}, 32'd1);
    tick();
    xfer("rd00_after", 1'b0, 32'h00, 3'b010, 32'h0, 1, 1'b0, 32'h5555_AAAA);

    addr(1'b1, 32'h10, 3'b010);
    tick();
    idle();
    hwdata = 32'hCAFE_F00D;
    @(negedge hclk);
    check("rstw_wait", {31'b0, rdy}, 32'd0);
    #1 hresetn = 1'b0;
    #1;
    check("rstw_rdy_async", {31'b0, rdy}, 32'd1);
    check("rstw_resp_async", {31'b0, resp}, 32'd0);
    tick();
    tick();
    hresetn = 1'b1;
    tick();
    xfer("rd10_post", 1'b0, 32'h10, 3'b010, 32'h0, 1, 1'b0, 32'h0);
    xfer("rd08_post", 1'b0, 32'h08, 3'b010, 32'h0, 1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
